// File: rtl/ac_pkg.sv
// ac_pkg: shared types, default parameters and helpers for the A/C thermostat.
// The saturating step helper serves both setpoint entry and temperature slew.
package ac_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_INC  = 2'd1,
    CMD_DEC  = 2'd2
  } cmd_state_t;

  localparam int unsigned DEF_TEMP_BITS = 3;
  localparam int unsigned DEF_TEMP_MIN  = 0;
  localparam int unsigned DEF_SET_DIV   = 2;
  localparam int unsigned DEF_SLEW_DIV  = 4;
  localparam int unsigned DEF_DRIP_MAX  = 10;
  localparam int unsigned DEF_DRY_TICKS = 3;

  // One step toward tgt; holds once equal, so it saturates at tgt.
  function automatic int unsigned step_toward(
    input int unsigned cur,
    input int unsigned tgt
  );
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/ac_thermostat_if.sv
// ac_thermostat_if: button/switch inputs and LED-bank outputs of the
// thermostat. master = switch bank side, slave = controller side.
interface ac_thermostat_if #(
  parameter int unsigned TEMP_BITS = 3
);

  logic                 inc;
  logic                 dec;
  logic                 power;
  logic [TEMP_BITS-1:0] ambient;
  logic [TEMP_BITS-1:0] desired_temp;
  logic [TEMP_BITS-1:0] real_temp;
  logic                 drip_full;
  logic                 heartbeat;
  logic [1:0]           cmd_state;

  modport master (
    output inc,
    output dec,
    output power,
    output ambient,
    input  desired_temp,
    input  real_temp,
    input  drip_full,
    input  heartbeat,
    input  cmd_state
  );

  modport slave (
    input  inc,
    input  dec,
    input  power,
    input  ambient,
    output desired_temp,
    output real_temp,
    output drip_full,
    output heartbeat,
    output cmd_state
  );

endinterface

// File: rtl/ac_thermostat_tick_divider.sv
// tick_divider: free-running 0..DIV-1 counter, one-cycle tick on the last
// count. DIV=1 gives a tick every cycle.
module tick_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ac_thermostat.sv
// ac_thermostat: setpoint FSM, slewed room temperature and drip tray model.
// Drip tray is built only when AC_DRIP_EN is defined; else drip_full = 0.
module ac_thermostat
  import ac_pkg::*;
#(
  parameter int unsigned TEMP_BITS = DEF_TEMP_BITS,
  parameter int unsigned TEMP_MAX  = (2 ** TEMP_BITS) - 1,
  parameter int unsigned TEMP_MIN  = DEF_TEMP_MIN,
  parameter int unsigned SET_DIV   = DEF_SET_DIV,
  parameter int unsigned SLEW_DIV  = DEF_SLEW_DIV,
  parameter int unsigned DRIP_MAX  = DEF_DRIP_MAX,
  parameter int unsigned DRY_TICKS = DEF_DRY_TICKS
) (
  input logic            clk_2,
  input logic            reset,
  ac_thermostat_if.slave bus
);

  localparam logic [TEMP_BITS-1:0] T_MIN = TEMP_BITS'(TEMP_MIN);

  logic set_tick;
  logic slew_tick;

  cmd_state_t           cmd_q, cmd_d;
  logic [TEMP_BITS-1:0] des_q, des_d;
  logic [TEMP_BITS-1:0] real_q, real_d;
  logic [TEMP_BITS-1:0] tgt;
  logic                 hb_q, hb_d;

  tick_divider #(.DIV(SET_DIV)) u_set_div (
    .clk   (clk_2),
    .rst_n (reset),
    .tick  (set_tick)
  );

  tick_divider #(.DIV(SLEW_DIV)) u_slew_div (
    .clk   (clk_2),
    .rst_n (reset),
    .tick  (slew_tick)
  );

  always_comb begin
    cmd_d = cmd_q;
    if (set_tick) begin
      unique case (1'b1)
        bus.inc && !bus.dec: cmd_d = CMD_INC;
        bus.dec && !bus.inc: cmd_d = CMD_DEC;
        default:             cmd_d = CMD_IDLE;
      endcase
    end
  end

  // Setpoint acts on the command latched at the previous tick.
  always_comb begin
    des_d = des_q;
    if (set_tick) begin
      unique case (cmd_q)
        CMD_INC:
          des_d = TEMP_BITS'(step_toward(32'(des_q), TEMP_MAX));
        CMD_DEC:
          des_d = TEMP_BITS'(step_toward(32'(des_q), TEMP_MIN));
        default:
          des_d = des_q;
      endcase
    end
  end

  always_comb begin
    tgt    = bus.power ? des_q : bus.ambient;
    real_d = real_q;
    if (slew_tick)
      real_d = TEMP_BITS'(step_toward(32'(real_q), 32'(tgt)));
  end

  assign hb_d = hb_q ^ set_tick;

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      cmd_q  <= CMD_IDLE;
      des_q  <= T_MIN;
      real_q <= T_MIN;
      hb_q   <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      des_q  <= des_d;
      real_q <= real_d;
      hb_q   <= hb_d;
    end
  end

  assign bus.desired_temp = des_q;
  assign bus.real_temp    = real_q;
  assign bus.heartbeat    = hb_q;
  assign bus.cmd_state    = cmd_q;

`ifdef AC_DRIP_EN
  localparam int unsigned DRW = cnt_w(DRIP_MAX);
  localparam int unsigned DYW = cnt_w(DRY_TICKS);
  localparam logic [TEMP_BITS-1:0] T_MAX = TEMP_BITS'(TEMP_MAX);
  localparam logic [DRW-1:0] DRIP_LIM = DRW'(DRIP_MAX);
  localparam logic [DYW-1:0] DRY_LIM  = DYW'(DRY_TICKS);

  logic [DRW-1:0] drip_q, drip_d;
  logic [DYW-1:0] dry_q, dry_d;
  logic [DRW-1:0] drip_up;

  assign drip_up = DRW'(step_toward(32'(drip_q), DRIP_MAX));

  // Uses pre-update real_q even when a slew lands on the same edge.
  always_comb begin
    drip_d = drip_q;
    dry_d  = dry_q;
    if (set_tick) begin
      if (real_q != T_MAX) begin
        dry_d  = '0;
        drip_d = drip_up;
      end else begin
        dry_d  = DYW'(step_toward(32'(dry_q), DRY_TICKS));
        drip_d = (dry_q == DRY_LIM) ? '0 : drip_up;
      end
    end
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      drip_q <= '0;
      dry_q  <= '0;
    end else begin
      drip_q <= drip_d;
      dry_q  <= dry_d;
    end
  end

  assign bus.drip_full = (drip_q == DRIP_LIM);
`else
  logic unused_drip_cfg;
  assign unused_drip_cfg = ^{DRIP_MAX, DRY_TICKS};
  assign bus.drip_full   = 1'b0;
`endif

endmodule

// File: tb/tb_ac_thermostat.sv
// tb_ac_thermostat: directed plus random stimulus for ac_thermostat,
// checked every cycle against a behavioural model of the controller.
module tb_ac_thermostat;

  localparam int T_MAX     = 7;
  localparam int T_MIN     = 0;
  localparam int SET_DIV   = 2;
  localparam int SLEW_DIV  = 4;
  localparam int DRIP_MAX  = 10;
  localparam int DRY_TICKS = 3;

  logic clk_2 = 1'b0;
  logic reset = 1'b0;

  ac_thermostat_if #(.TEMP_BITS(3)) bus_if ();

  ac_thermostat dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk_2 = ~clk_2;

  int vectors     = 0;
  int miscompares = 0;

  int n;
  int m_cmd;
  int m_des;
  int m_real;
  int m_drip;
  int m_dry;
  int m_hb;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    m_cmd  = 0;
    m_des  = T_MIN;
    m_real = T_MIN;
    m_drip = 0;
    m_dry  = 0;
    m_hb   = 0;
  endtask

  function automatic int exp_drip_full();
`ifdef AC_DRIP_EN
    return (m_drip == DRIP_MAX) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Applies the rules of one clock edge with inputs held over the cycle.
  task automatic model_edge();
    bit st;
    bit sl;
    int d0;
    int r0;
    int tgt;
    st = (n % SET_DIV) == SET_DIV - 1;
    sl = (n % SLEW_DIV) == SLEW_DIV - 1;
    d0 = m_des;
    r0 = m_real;
    if (st) begin
      if (m_cmd == 1) m_des = (d0 < T_MAX) ? d0 + 1 : T_MAX;
      if (m_cmd == 2) m_des = (d0 > T_MIN) ? d0 - 1 : T_MIN;
      if (bus_if.inc && !bus_if.dec)      m_cmd = 1;
      else if (bus_if.dec && !bus_if.inc) m_cmd = 2;
      else                                m_cmd = 0;
      m_hb = 1 - m_hb;
      if (r0 != T_MAX) begin
        m_dry  = 0;
        m_drip = (m_drip < DRIP_MAX) ? m_drip + 1 : DRIP_MAX;
      end else begin
        if (m_dry == DRY_TICKS) m_drip = 0;
        else m_drip = (m_drip < DRIP_MAX) ? m_drip + 1 : DRIP_MAX;
        m_dry = (m_dry < DRY_TICKS) ? m_dry + 1 : DRY_TICKS;
      end
    end
    if (sl) begin
      tgt = bus_if.power ? d0 : int'(bus_if.ambient);
      if (r0 < tgt)      m_real = r0 + 1;
      else if (r0 > tgt) m_real = r0 - 1;
    end
    n++;
  endtask

  task automatic check_all();
    chk("desired_temp", 32'(bus_if.desired_temp), m_des);
    chk("real_temp", 32'(bus_if.real_temp), m_real);
    chk("cmd_state", 32'(bus_if.cmd_state), m_cmd);
    chk("heartbeat", 32'(bus_if.heartbeat), m_hb);
    chk("drip_full", 32'(bus_if.drip_full), exp_drip_full());
  endtask

  task automatic step();
    @(posedge clk_2);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic release_reset();
    @(negedge clk_2);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_desired"}, 32'(bus_if.desired_temp), 0);
    chk({pfx, "_real"}, 32'(bus_if.real_temp), 0);
    chk({pfx, "_cmd"}, 32'(bus_if.cmd_state), 0);
    chk({pfx, "_hb"}, 32'(bus_if.heartbeat), 0);
    chk({pfx, "_drip"}, 32'(bus_if.drip_full), 0);
  endtask

  initial begin
    bus_if.inc     = 1'b0;
    bus_if.dec     = 1'b0;
    bus_if.power   = 1'b1;
    bus_if.ambient = 3'd0;
    model_reset();
    #12;
    check_zero("reset");
    release_reset();

    bus_if.inc = 1'b1;
    run(24);
    chk("inc_saturate", 32'(bus_if.desired_temp), 7);
    bus_if.inc = 1'b0;
    run(28);
    chk("real_reach_max", 32'(bus_if.real_temp), 7);

    bus_if.inc = 1'b1;
    bus_if.dec = 1'b1;
    run(8);
    chk("both_cmd_idle", 32'(bus_if.cmd_state), 0);
    chk("both_des_hold", 32'(bus_if.desired_temp), 7);

    bus_if.inc = 1'b0;
    for (int i = 0; i < 40 && !(m_cmd == 2 && m_des == 6); i++) step();
    bus_if.dec = 1'b0;
    for (int i = 0; i < 8 && m_cmd != 0; i++) step();
    run(16);
    chk("des_at_5", 32'(bus_if.desired_temp), 5);
    chk("real_at_5", 32'(bus_if.real_temp), 5);

    bus_if.power   = 1'b0;
    bus_if.ambient = 3'd2;
    run(20);
    chk("real_ambient", 32'(bus_if.real_temp), 2);
    chk("des_kept_5", 32'(bus_if.desired_temp), 5);

    bus_if.power = 1'b1;
    for (int i = 0; i < 24 && m_real != 4; i++) step();
    #2;
    reset = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    release_reset();
    step();
    step();
    chk("first_set_tick", 32'(bus_if.heartbeat), 1);

    run(22);
`ifdef AC_DRIP_EN
    chk("drip_after_12", 32'(bus_if.drip_full), 1);
`else
    chk("drip_after_12", 32'(bus_if.drip_full), 0);
`endif

    for (int i = 0; i < 400; i++) begin
      if (i % 4 == 0) begin
        bus_if.inc     = 1'($urandom_range(0, 1));
        bus_if.dec     = 1'($urandom_range(0, 1));
        bus_if.power   = ($urandom_range(0, 3) != 0);
        bus_if.ambient = 3'($urandom_range(0, 7));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
